alu_resp_checker: RTL

//  Response-side checker for the 32-bit ALU. Stores each issued operation in an in-order queue

---
 rtl/alu_resp_checker_if.sv | 33 +++
 rtl/alu_resp_checker.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_resp_checker_if.sv
// Issue/response/status bundle between the ALU response checker and its environment.
// The master side drives operations and ALU responses; the slave side is the checker.
interface alu_resp_checker_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int PW = $clog2(DEPTH) + 1;

  logic             IssueValid;
  logic             IssueReady;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [1:0]       ALUControl;
  logic             RespValid;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic [CNT_W-1:0] PassCount;
  logic [CNT_W-1:0] FailCount;
  logic             Mismatch;
  logic             Underflow;
  logic [PW-1:0]    Pending;

  modport master (
    output IssueValid, SrcA, SrcB, ALUControl, RespValid, ALUResult, Zero,
    input  IssueReady, PassCount, FailCount, Mismatch, Underflow, Pending
  );

  modport slave (
    input  IssueValid, SrcA, SrcB, ALUControl, RespValid, ALUResult, Zero,
    output IssueReady, PassCount, FailCount, Mismatch, Underflow, Pending
  );
endinterface

// File: rtl/alu_resp_checker.sv
// In-order response checker for the 32-bit ALU: queues expected results at issue, compares at response.
// Optional ALU_CHK_STOP_ON_FAIL_EN freezes the checker in a HALT state after the first failed compare.
module alu_resp_checker #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  alu_resp_checker_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1
`ifdef ALU_CHK_STOP_ON_FAIL_EN
    ,HALT  = 2'd2
`endif
  } state_t;

  state_t           state;
  state_t           next_state;

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [PW-1:0]    pend_count;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic             mismatch_q;
  logic             underflow_q;

  logic             halted;
  logic             full;
  logic             empty;
  logic             issue_ready;
  logic             push;
  logic             resp_seen;
  logic             pop;
  logic             resp_pass;
  logic             resp_fail;
  logic [WIDTH-1:0] exp_result;
  logic             exp_zero;
  logic [WIDTH:0]   head;

`ifdef ALU_CHK_STOP_ON_FAIL_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  // Ready and empty come purely from registered state, so an acceptance never depends on a same-cycle pop.
  assign full        = (pend_count == PW'(DEPTH));
  assign empty       = (pend_count == '0);
  assign issue_ready = !full && !halted;
  assign push        = bus.IssueValid && issue_ready;
  assign resp_seen   = bus.RespValid && !halted;
  assign pop         = resp_seen && !empty;

  always_comb begin
    exp_result = '0;
    case (bus.ALUControl)
      2'b00:   exp_result = bus.SrcA + bus.SrcB;
      2'b01:   exp_result = bus.SrcA - bus.SrcB;
      2'b10:   exp_result = bus.SrcA & bus.SrcB;
      default: exp_result = bus.SrcA | bus.SrcB;
    endcase
  end

  assign exp_zero  = (exp_result == '0);
  assign head      = mem[rd_ptr];
  assign resp_pass = (bus.ALUResult == head[WIDTH:1]) && (bus.Zero == head[0]);
  assign resp_fail = pop && !resp_pass;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {exp_result, exp_zero};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pend_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   pend_count <= pend_count + PW'(1);
        2'b01:   pend_count <= pend_count - PW'(1);
        default: pend_count <= pend_count;
      endcase
    end
  end

  // Statistics saturate rather than wrap so a long run never reports a misleadingly small count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_count  <= '0;
      fail_count  <= '0;
      mismatch_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mismatch_q <= resp_fail;
      if (pop && resp_pass && (pass_count != CNT_MAX)) begin
        pass_count <= pass_count + CNT_W'(1);
      end
      if (resp_fail && (fail_count != CNT_MAX)) begin
        fail_count <= fail_count + CNT_W'(1);
      end
      if (resp_seen && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (push) begin
          next_state = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pop && !push && (pend_count == PW'(1))) begin
          next_state = IDLE;
        end
      end
      default: next_state = state;
    endcase
`ifdef ALU_CHK_STOP_ON_FAIL_EN
    if (resp_fail) begin
      next_state = HALT;
    end
`endif
  end

  assign bus.IssueReady = issue_ready;
  assign bus.PassCount  = pass_count;
  assign bus.FailCount  = fail_count;
  assign bus.Mismatch   = mismatch_q;
  assign bus.Underflow  = underflow_q;
  assign bus.Pending    = pend_count;
endmodule
